// File: rtl/error_stage.sv
// Error stage: buffers targets, emits err = tgt - res one cycle after each result, tracks per-epoch |err| sums.
// Latency 1 (res -> err); a full error register or an empty target FIFO stalls results.
module error_stage #(
  parameter int RES_WIDTH = 8,
  parameter int ERR_WIDTH = 16,  // must be >= RES_WIDTH + 3
  parameter int TGT_DEPTH = 4,
  parameter int EPOCH     = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 tgt_valid,
  input  logic [RES_WIDTH-1:0] tgt_data,
  output logic                 tgt_ready,
  input  logic                 res_valid,
  input  logic [RES_WIDTH-1:0] res_data,
  output logic                 res_ready,
  output logic                 err_valid,
  output logic [ERR_WIDTH-1:0] err_data,
  input  logic                 err_ready,
  output logic                 epoch_valid,
  output logic [ERR_WIDTH-1:0] epoch_sum,
  output logic                 converged
);

  localparam int AW = $clog2(TGT_DEPTH);
  localparam int CW = $clog2(EPOCH + 1);
  localparam int DW = RES_WIDTH + 2;

  logic [RES_WIDTH-1:0] mem_q [TGT_DEPTH];
  logic [RES_WIDTH-1:0] mem_d [TGT_DEPTH];
  logic [AW:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic                 err_valid_q, err_valid_d;
  logic [ERR_WIDTH-1:0] err_data_q, err_data_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [ERR_WIDTH-1:0] acc_q, acc_d;
  logic [ERR_WIDTH-1:0] epoch_sum_q, epoch_sum_d;
  logic                 epoch_valid_q, epoch_valid_d;
  logic                 converged_q, converged_d;

  logic                 full, empty, push, pop, epoch_end;
  logic [RES_WIDTH-1:0] head;
  logic signed [DW-1:0] diff, neg_diff;
  logic [RES_WIDTH:0]   abs_err;
  logic [ERR_WIDTH:0]   acc_sum;
  logic [ERR_WIDTH-1:0] total;

  // Extra pointer MSB distinguishes full from empty when the index bits match.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  assign tgt_ready = !full;
  assign res_ready = !empty && (!err_valid_q || err_ready);
  assign push      = tgt_valid && !full;
  assign pop       = res_valid && res_ready;
  assign head      = mem_q[rd_ptr_q[AW-1:0]];

  assign diff     = $signed({2'b00, head}) - $signed({2'b00, res_data});
  assign neg_diff = -diff;
  assign abs_err  = diff[DW-1] ? neg_diff[RES_WIDTH:0] : diff[RES_WIDTH:0];
  assign acc_sum  = {1'b0, acc_q} + {{(ERR_WIDTH-RES_WIDTH){1'b0}}, abs_err};
  assign total    = acc_sum[ERR_WIDTH] ? '1 : acc_sum[ERR_WIDTH-1:0];
  assign epoch_end = (cnt_q == CW'(EPOCH - 1));

  always_comb begin
    mem_d         = mem_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    err_valid_d   = err_valid_q;
    err_data_d    = err_data_q;
    cnt_d         = cnt_q;
    acc_d         = acc_q;
    epoch_sum_d   = epoch_sum_q;
    epoch_valid_d = 1'b0;
    converged_d   = converged_q;

    if (push) begin
      mem_d[wr_ptr_q[AW-1:0]] = tgt_data;
      wr_ptr_d = wr_ptr_q + (AW+1)'(1);
    end

    if (pop) begin
      rd_ptr_d    = rd_ptr_q + (AW+1)'(1);
      err_valid_d = 1'b1;
      err_data_d  = {{(ERR_WIDTH-DW){diff[DW-1]}}, diff};
    end else if (err_ready) begin
      err_valid_d = 1'b0;
    end

    // The sample that completes an epoch is folded into the reported sum.
    if (pop && en) begin
      if (epoch_end) begin
        epoch_sum_d   = total;
        converged_d   = (total == '0);
        epoch_valid_d = 1'b1;
        cnt_d         = '0;
        acc_d         = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
        acc_d = total;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q         <= '{default: '0};
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      err_valid_q   <= 1'b0;
      err_data_q    <= '0;
      cnt_q         <= '0;
      acc_q         <= '0;
      epoch_sum_q   <= '0;
      epoch_valid_q <= 1'b0;
      converged_q   <= 1'b0;
    end else begin
      mem_q         <= mem_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      err_valid_q   <= err_valid_d;
      err_data_q    <= err_data_d;
      cnt_q         <= cnt_d;
      acc_q         <= acc_d;
      epoch_sum_q   <= epoch_sum_d;
      epoch_valid_q <= epoch_valid_d;
      converged_q   <= converged_d;
    end
  end

  assign err_valid   = err_valid_q;
  assign err_data    = err_data_q;
  assign epoch_valid = epoch_valid_q;
  assign epoch_sum   = epoch_sum_q;
  assign converged   = converged_q;

endmodule

// File: tb/tb_error_stage.sv
// Directed bench for error_stage with default parameters.
module tb_error_stage;

  logic        clk;
  logic        rst;
  logic        en;
  logic        tgt_valid;
  logic [7:0]  tgt_data;
  logic        tgt_ready;
  logic        res_valid;
  logic [7:0]  res_data;
  logic        res_ready;
  logic        err_valid;
  logic [15:0] err_data;
  logic        err_ready;
  logic        epoch_valid;
  logic [15:0] epoch_sum;
  logic        converged;

  int n_cmp = 0;
  int n_err = 0;

  error_stage dut (
    .clk(clk), .rst(rst), .en(en),
    .tgt_valid(tgt_valid), .tgt_data(tgt_data), .tgt_ready(tgt_ready),
    .res_valid(res_valid), .res_data(res_data), .res_ready(res_ready),
    .err_valid(err_valid), .err_data(err_data), .err_ready(err_ready),
    .epoch_valid(epoch_valid), .epoch_sum(epoch_sum), .converged(converged)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] d);
    int n;
    tgt_valid = 1'b1;
    tgt_data  = d;
    #1;
    n = 0;
    while (!tgt_ready && n < 50) begin
      step();
      n++;
    end
    if (n == 50) check("push_timeout", 0, 1);
    step();
    tgt_valid = 1'b0;
  endtask

  task automatic send_res(input logic [7:0] d);
    int n;
    res_valid = 1'b1;
    res_data  = d;
    #1;
    n = 0;
    while (!res_ready && n < 50) begin
      step();
      n++;
    end
    if (n == 50) check("res_timeout", 0, 1);
    step();
    res_valid = 1'b0;
  endtask

  // Samples packed with sample 0 in the low byte.
  task automatic run_epoch(input logic [31:0] t, input logic [31:0] r, input logic exp_pulse,
                           input logic [15:0] exp_sum, input logic exp_conv);
    logic [15:0] e;
    for (int i = 0; i < 4; i++) push(t[8*i +: 8]);
    err_ready = 1'b1;
    res_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      res_data = r[8*i +: 8];
      #1;
      check("ep_res_ready", res_ready, 1);
      step();
      e = {8'h00, t[8*i +: 8]} - {8'h00, r[8*i +: 8]};
      check("ep_err_valid", err_valid, 1);
      check("ep_err_data", err_data, e);
      check("ep_pulse", epoch_valid, (i == 3) && exp_pulse);
    end
    res_valid = 1'b0;
    check("ep_sum", epoch_sum, exp_sum);
    check("ep_conv", converged, exp_conv);
    step();
    check("ep_pulse_end", epoch_valid, 0);
    check("ep_sum_hold", epoch_sum, exp_sum);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; err_ready = 1'b1;
    tgt_valid = 1'b0; tgt_data = '0; res_valid = 1'b0; res_data = '0;
    step();
    step();
    check("rst_err_valid", err_valid, 0);
    check("rst_res_ready", res_ready, 0);
    rst = 1'b0;
    #1;
    check("post_rst_tgt_ready", tgt_ready, 1);
    check("post_rst_res_ready", res_ready, 0);
    check("post_rst_err_data", err_data, 0);
    check("post_rst_epoch_valid", epoch_valid, 0);
    check("post_rst_epoch_sum", epoch_sum, 0);
    check("post_rst_converged", converged, 0);

    // Basic signed error
    push(8'hFF);
    check("res_ready_nonempty", res_ready, 1);
    send_res(8'h00);
    check("ff_minus_0_valid", err_valid, 1);
    check("ff_minus_0", err_data, 16'h00FF);
    push(8'h00);
    send_res(8'hFF);
    check("0_minus_ff", err_data, 16'hFF01);
    step();
    check("err_valid_clear", err_valid, 0);

    // FIFO full, held fifth target, order across wrap
    push(8'h10); push(8'h20); push(8'h30); push(8'h40);
    check("full_tgt_ready", tgt_ready, 0);
    tgt_valid = 1'b1; tgt_data = 8'h50;
    step();
    check("held_tgt_ready", tgt_ready, 0);
    res_valid = 1'b1; res_data = 8'h00;
    step();
    check("pop_0x10", err_data, 16'h0010);
    check("ready_after_pop", tgt_ready, 1);
    step();
    tgt_valid = 1'b0;
    check("pop_0x20", err_data, 16'h0020);
    step();
    check("pop_0x30", err_data, 16'h0030);
    step();
    check("pop_0x40", err_data, 16'h0040);
    step();
    check("pop_0x50", err_data, 16'h0050);
    check("drained_res_ready", res_ready, 0);
    res_valid = 1'b0;
    step();
    check("drained_err_valid", err_valid, 0);

    // Downstream backpressure
    push(8'hAA); push(8'hBB); push(8'hCC);
    err_ready = 1'b0;
    send_res(8'h0A);
    check("bp_err_A0", err_data, 16'h00A0);
    res_valid = 1'b1; res_data = 8'h0B;
    #1;
    check("bp_res_ready", res_ready, 0);
    step();
    check("bp_hold_valid", err_valid, 1);
    check("bp_hold_data1", err_data, 16'h00A0);
    step();
    check("bp_hold_data2", err_data, 16'h00A0);
    err_ready = 1'b1;
    #1;
    check("bp_release_ready", res_ready, 1);
    step();
    check("b2b_B0", err_data, 16'h00B0);
    res_data = 8'h0C;
    step();
    check("b2b_valid", err_valid, 1);
    check("b2b_C0", err_data, 16'h00C0);
    res_valid = 1'b0;
    step();
    check("b2b_done", err_valid, 0);

    // Epoch statistics
    en = 1'b1;
    run_epoch(32'hFF000000, 32'hFF000000, 1'b1, 16'h0000, 1'b1);
    en = 1'b0;
    run_epoch(32'h05050505, 32'h00000000, 1'b0, 16'h0000, 1'b1);
    en = 1'b1;
    run_epoch(32'hFF000000, 32'hF0000010, 1'b1, 16'h001F, 1'b0);

    // Reset mid-epoch with full FIFO and pending error
    push(8'h08); send_res(8'h00);
    push(8'h08); send_res(8'h00);
    push(8'h08);
    err_ready = 1'b0;
    send_res(8'h00);
    push(8'h11); push(8'h11); push(8'h11); push(8'h11);
    check("pre_rst_full", tgt_ready, 0);
    check("pre_rst_err_valid", err_valid, 1);
    check("pre_rst_err_data", err_data, 16'h0008);
    rst = 1'b1; err_ready = 1'b1;
    res_valid = 1'b1; res_data = 8'h00;
    tgt_valid = 1'b1; tgt_data = 8'h77;
    #1;
    check("pre_rst_res_ready", res_ready, 1);
    step();
    rst = 1'b0; res_valid = 1'b0; tgt_valid = 1'b0;
    #1;
    check("mid_rst_tgt_ready", tgt_ready, 1);
    check("mid_rst_res_ready", res_ready, 0);
    check("mid_rst_err_valid", err_valid, 0);
    check("mid_rst_err_data", err_data, 0);
    check("mid_rst_epoch_valid", epoch_valid, 0);
    check("mid_rst_epoch_sum", epoch_sum, 0);
    check("mid_rst_converged", converged, 0);
    run_epoch(32'h04030201, 32'h00000000, 1'b1, 16'h000A, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/error_stage.md
ERROR_STAGE -- requirements
Module: error_stage

Interface
REQ-001 SHALL have parameter RES_WIDTH, default 8, width of the result and target words (unsigned).
REQ-002 SHALL have parameter ERR_WIDTH, default 16, width of the signed error word and of the epoch absolute-error sum.
REQ-003 SHALL have parameter TGT_DEPTH, default 4, depth of the target FIFO (power of two, >= 2).
REQ-004 SHALL have parameter EPOCH, default 4, number of samples per epoch (>= 1).
REQ-005 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-006 SHALL have port rst, input, 1, reset; synchronous, active-high.
REQ-007 SHALL have port en, input, 1, training enable; gates statistics only.
REQ-008 SHALL have port tgt_valid, input, 1, target word offered.
REQ-009 SHALL have port tgt_data, input, RES_WIDTH, target value.
REQ-010 SHALL have port tgt_ready, output, 1, target FIFO can accept.
REQ-011 SHALL have port res_valid, input, 1, perceptron result offered.
REQ-012 SHALL have port res_data, input, RES_WIDTH, perceptron result.
REQ-013 SHALL have port res_ready, output, 1, result consumed this cycle when res_valid is also high.
REQ-014 SHALL have port err_valid, output, 1, error word available.
REQ-015 SHALL have port err_data, output, ERR_WIDTH, signed error tgt - res.
REQ-016 SHALL have port err_ready, input, 1, downstream (perceptron backward port) accepts the error.
REQ-017 SHALL have port epoch_valid, output, 1, one-cycle pulse at epoch end.
REQ-018 SHALL have port epoch_sum, output, ERR_WIDTH, unsigned sum of |err| over the last completed epoch.
REQ-019 SHALL have port converged, output, 1, high when the last completed epoch had epoch_sum == 0.

Function
REQ-020 SHALL make every handshake a transfer only when valid and ready are both high on a rising clk edge; valid SHALL NOT depend combinationally on ready.
REQ-021 SHALL buffer targets in a TGT_DEPTH FIFO; tgt_ready = !full, and a push SHALL be refused when full even if a pop occurs in the same cycle.
REQ-022 SHALL assert res_ready = !fifo_empty && (!err_valid || err_ready); an empty FIFO SHALL stall results, with no same-cycle bypass of a target pushed in that cycle.
REQ-023 SHALL, on a result transfer, pop the FIFO head and register err_data = $signed({1'b0,tgt}) - $signed({1'b0,res}), sign-extended to ERR_WIDTH, with err_valid = 1 the next cycle (latency 1).
REQ-024 SHALL clear err_valid after an err transfer with no new result transfer in the same cycle; with a simultaneous transfer SHALL load the new error and keep err_valid high (full throughput, one sample per cycle).
REQ-025 SHALL hold err_data stable while err_valid && !err_ready.
REQ-026 SHALL, when en = 1 at a result transfer, add |err| to an internal accumulator, saturating at 2^ERR_WIDTH-1, and increment a sample counter.
REQ-027 SHALL, when the sample counter reaches EPOCH, update epoch_sum with the accumulator total including the current sample, set converged = (total == 0), pulse epoch_valid for one cycle, and clear the counter and accumulator in the same cycle (wrap).
REQ-028 SHALL, when en = 0, leave counter, accumulator, epoch_sum, converged unchanged and produce no epoch_valid, while the error stream continues to operate.
REQ-029 SHALL hold epoch_sum and converged until the next epoch end or reset.
REQ-030 SHALL keep the FIFO order strictly first-in first-out across pointer wrap-around.

Reset
REQ-031 SHALL, while rst is high at a clk edge, empty the FIFO, set err_valid = 0, err_data = 0, epoch_valid = 0, epoch_sum = 0, converged = 0, and clear the counter and accumulator; rst SHALL take priority over any simultaneous transfer.
REQ-032 SHALL drive tgt_ready = 1 and res_ready = 0 in the first cycle after reset deasserts.

Verification
REQ-033 SHALL pass the following: single sample, tgt 0xFF then res 0x00, err_ready = 1 -> err_data 0x00FF one cycle after the res transfer; tgt 0x00, res 0xFF -> err_data 0xFF01.
REQ-034 SHALL pass the following: push 4 targets with no results -> tgt_ready = 0; a fifth target is held; pop one via a result -> fifth target accepted the next cycle, order preserved.
REQ-035 SHALL pass the following: err_ready = 0 with err_valid high -> res_ready = 0 and err_data stable; then raise err_ready with res_valid held -> back-to-back errors, one per cycle.
REQ-036 SHALL pass the following: en = 1, EPOCH = 4, AND truth table targets 00,00,00,FF against results 00,00,00,FF -> epoch_valid pulse, epoch_sum 0, converged 1; against results 10,00,00,F0 -> epoch_sum 0x001F, converged 0.
REQ-037 SHALL pass the following: en = 0 for 4 samples after a converged epoch -> no epoch_valid pulse, epoch_sum and converged unchanged, errors still emitted.
REQ-038 SHALL pass the following: rst asserted mid-epoch with a full FIFO and err_valid high -> next cycle all outputs at reset values; the next 4 samples form a fresh epoch.
